// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
//   CPU datapath register bank: DEPTH = 2**ADDR_W entries of DATA_W bits,
//   one write port, two registered read ports (1-cycle latency), optional
//   hardwired-zero entry 0, optional write-to-read bypass, and a sequenced
//   bulk-clear engine that zeroes one entry per cycle without reset.
//
// Ports
//   CLK          clock, all state updates on the rising edge
//   reset        asynchronous active-high reset
//   RegWrite     write enable (ignored while a clear runs)
//   WriteReg     write address
//   write_data   write data
//   rd_en        read request for both read ports
//   ReadReg1/2   read addresses
//   read_data1/2 registered read data (held while rd_en is low)
//   rd_valid     high the cycle after a sampled rd_en
//   clear_start  bulk-clear request (level sampled at the edge)
//   clear_busy   high while the clear sequence runs (DEPTH cycles)
//   clear_done   one-cycle pulse after the final clear write
// ---------------------------------------------------------------------------
module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic              rd_valid,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;

    logic [DATA_W-1:0] regs [DEPTH];

    // Effective write: the clear engine owns the write port while it runs.
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic [DATA_W-1:0] rd_next1;
    logic [DATA_W-1:0] rd_next2;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = WriteReg;
        wr_data = write_data;
        if (state == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt;
            wr_data = '0;
        end else if (RegWrite) begin
            wr_en = 1'b1;
        end
        // Writes to the hardwired-zero entry are discarded.
        if ((ZERO_REG != 0) && (wr_addr == '0)) begin
            wr_en = 1'b0;
        end
    end

    // Read-side selection: zero entry overrides bypass, bypass overrides array.
    always_comb begin
        rd_next1 = regs[ReadReg1];
        if ((BYPASS != 0) && wr_en && (wr_addr == ReadReg1)) begin
            rd_next1 = wr_data;
        end
        if ((ZERO_REG != 0) && (ReadReg1 == '0)) begin
            rd_next1 = '0;
        end

        rd_next2 = regs[ReadReg2];
        if ((BYPASS != 0) && wr_en && (wr_addr == ReadReg2)) begin
            rd_next2 = wr_data;
        end
        if ((ZERO_REG != 0) && (ReadReg2 == '0)) begin
            rd_next2 = '0;
        end
    end

    // Storage array
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Registered read ports
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            read_data1 <= '0;
            read_data2 <= '0;
            rd_valid   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                read_data1 <= rd_next1;
                read_data2 <= rd_next2;
            end
        end
    end

    // Bulk-clear sequencer
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            clear_busy <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clear_done <= 1'b0;
                    if (clear_start) begin
                        state      <= CLEAR;
                        clr_cnt    <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        clear_done <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    clear_busy <= 1'b0;
                    clear_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// ---------------------------------------------------------------------------
// tb_reg_file_param
//   Two instances share all inputs: dut_a uses ZERO_REG=1/BYPASS=1,
//   dut_b uses ZERO_REG=0/BYPASS=0. Each step drives one edge worth of
//   stimulus, pushes the expected read result to a queue, and pops/compares
//   it one cycle later. Expected values are hand-derived per vector.
// ---------------------------------------------------------------------------
module tb_reg_file_param;

    logic        CLK;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] write_data;
    logic        rd_en;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic        clear_start;

    logic [31:0] rd1a, rd2a, rd1b, rd2b;
    logic        rva, rvb, busya, busyb, donea, doneb;

    reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .CLK(CLK), .reset(reset), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .write_data(write_data), .rd_en(rd_en), .ReadReg1(ReadReg1),
        .ReadReg2(ReadReg2), .read_data1(rd1a), .read_data2(rd2a),
        .rd_valid(rva), .clear_start(clear_start), .clear_busy(busya),
        .clear_done(donea)
    );

    reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .CLK(CLK), .reset(reset), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .write_data(write_data), .rd_en(rd_en), .ReadReg1(ReadReg1),
        .ReadReg2(ReadReg2), .read_data1(rd1b), .read_data2(rd2b),
        .rd_valid(rvb), .clear_start(clear_start), .clear_busy(busyb),
        .clear_done(doneb)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic        cs;
        logic [31:0] e1a;
        logic [31:0] e2a;
        logic [31:0] e1b;
        logic [31:0] e2b;
    } vec_t;

    typedef struct {
        logic        valid;
        logic [31:0] d1a;
        logic [31:0] d2a;
        logic [31:0] d1b;
        logic [31:0] d2b;
    } exp_t;

    int   n_checks;
    int   n_errors;
    exp_t sb[$];
    exp_t held;
    vec_t tbl[13];

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic re, input logic [4:0] a1, input logic [4:0] a2,
                                input logic cs, input logic [31:0] e1a, input logic [31:0] e2a,
                                input logic [31:0] e1b, input logic [31:0] e2b);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.a1 = a1; v.a2 = a2; v.cs = cs;
        v.e1a = e1a; v.e2a = e2a; v.e1b = e1b; v.e2b = e2b;
        return v;
    endfunction

    function automatic vec_t idle_vec();
        return mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_fsm(input string tag, input logic eb, input logic ed);
        chk({tag, " busy_a"}, {31'b0, busya}, {31'b0, eb});
        chk({tag, " done_a"}, {31'b0, donea}, {31'b0, ed});
        chk({tag, " busy_b"}, {31'b0, busyb}, {31'b0, eb});
        chk({tag, " done_b"}, {31'b0, doneb}, {31'b0, ed});
    endtask

    // One clock edge: drive, queue the expectation, advance, pop and compare.
    task automatic step(input vec_t v, input string tag);
        exp_t e;
        RegWrite    = v.we;
        WriteReg    = v.wa;
        write_data  = v.wd;
        rd_en       = v.re;
        ReadReg1    = v.a1;
        ReadReg2    = v.a2;
        clear_start = v.cs;
        if (v.re) begin
            e.valid = 1'b1;
            e.d1a = v.e1a; e.d2a = v.e2a; e.d1b = v.e1b; e.d2b = v.e2b;
        end else begin
            e = held;
            e.valid = 1'b0;
        end
        held = e;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        chk({tag, " rd1_a"}, rd1a, e.d1a);
        chk({tag, " rd2_a"}, rd2a, e.d2a);
        chk({tag, " rd1_b"}, rd1b, e.d1b);
        chk({tag, " rd2_b"}, rd2b, e.d2b);
        chk({tag, " valid_a"}, {31'b0, rva}, {31'b0, e.valid});
        chk({tag, " valid_b"}, {31'b0, rvb}, {31'b0, e.valid});
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic async_reset(input string tag);
        #3 reset = 1'b1;
        #1;
        chk({tag, " rd1_a"}, rd1a, 32'h0);
        chk({tag, " rd2_a"}, rd2a, 32'h0);
        chk({tag, " rd1_b"}, rd1b, 32'h0);
        chk({tag, " rd2_b"}, rd2b, 32'h0);
        chk({tag, " valid_a"}, {31'b0, rva}, 32'h0);
        chk({tag, " valid_b"}, {31'b0, rvb}, 32'h0);
        chk_fsm(tag, 1'b0, 1'b0);
        #2 reset = 1'b0;
        held = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   busy_cnt;
        int   done_cnt;

        n_checks = 0;
        n_errors = 0;
        held = '{1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
        reset = 1'b1;
        RegWrite = 1'b0; WriteReg = '0; write_data = '0;
        rd_en = 1'b0; ReadReg1 = '0; ReadReg2 = '0; clear_start = 1'b0;

        //            we  wa     wd             re  a1     a2     cs  e1a            e2a            e1b            e2b
        tbl[0]  = mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  5'd0,  0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 5'd0,  32'h0,        1, 5'd5,  5'd0,  0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0);
        tbl[2]  = mk(0, 5'd0,  32'h0,        0, 5'd0,  5'd0,  0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 5'd0,  32'h1234,     0, 5'd0,  5'd0,  0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 5'd0,  32'h0,        1, 5'd0,  5'd0,  0, 32'h0, 32'h0, 32'h1234, 32'h1234);
        tbl[5]  = mk(1, 5'd7,  32'h11,       0, 5'd0,  5'd0,  0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 5'd7,  32'hA5A5A5A5, 1, 5'd7,  5'd5,  0, 32'hA5A5A5A5, 32'hDEADBEEF, 32'h11, 32'hDEADBEEF);
        tbl[7]  = mk(0, 5'd0,  32'h0,        1, 5'd7,  5'd7,  0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
        tbl[8]  = mk(1, 5'd9,  32'hCAFE0009, 1, 5'd9,  5'd3,  0, 32'hCAFE0009, 32'h0, 32'h0, 32'h0);
        tbl[9]  = mk(1, 5'd0,  32'h5555,     1, 5'd0,  5'd0,  0, 32'h0, 32'h0, 32'h1234, 32'h1234);
        tbl[10] = mk(0, 5'd0,  32'h0,        1, 5'd0,  5'd9,  0, 32'h0, 32'hCAFE0009, 32'h5555, 32'hCAFE0009);
        tbl[11] = mk(1, 5'd31, 32'hFFFFFFFF, 1, 5'd31, 5'd1,  0, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
        tbl[12] = mk(0, 5'd0,  32'h0,        1, 5'd31, 5'd31, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);

        repeat (2) @(posedge CLK);
        #1 reset = 1'b0;
        chk("reset rd1_a", rd1a, 32'h0);
        chk("reset rd1_b", rd1b, 32'h0);
        chk("reset valid_a", {31'b0, rva}, 32'h0);
        chk_fsm("reset", 1'b0, 1'b0);

        // Write/read, hold, zero entry, bypass vectors
        for (int i = 0; i < 13; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-cycle, then every entry reads back zero
        v = idle_vec();
        step(v, "pre_reset");
        async_reset("async_rst");
        for (int i = 1; i < 32; i++) begin
            v = idle_vec();
            v.re = 1'b1; v.a1 = 5'(i); v.a2 = 5'(32 - i);
            step(v, $sformatf("post_rst_rd%0d", i));
        end

        // Fill 1..31 with their index, then bulk clear
        for (int i = 1; i < 32; i++) begin
            v = idle_vec();
            v.we = 1'b1; v.wa = 5'(i); v.wd = 32'(i);
            step(v, $sformatf("fill%0d", i));
        end
        v = idle_vec();
        v.cs = 1'b1;
        step(v, "clr_start");
        chk_fsm("clr_start", 1'b1, 1'b0);
        busy_cnt = busya ? 1 : 0;
        done_cnt = 0;
        // Edge j+1 after the start edge clears entry j; read it and its successor.
        for (int j = 0; j < 32; j++) begin
            v = idle_vec();
            v.we  = (j == 10);
            v.wa  = 5'd3;
            v.wd  = 32'h99;
            v.re  = 1'b1;
            v.a1  = 5'(j);
            v.a2  = 5'((j + 1) % 32);
            v.e1a = 32'h0;
            v.e1b = 32'(j);
            v.e2a = (j == 31) ? 32'h0 : 32'(j + 1);
            v.e2b = v.e2a;
            step(v, $sformatf("clr%0d", j));
            chk_fsm($sformatf("clr%0d", j), j < 31, j == 31);
            if (busya) busy_cnt++;
            if (donea) done_cnt++;
        end
        chk("clr busy_cycles", 32'(busy_cnt), 32'd32);
        chk("clr done_pulses", 32'(done_cnt), 32'd1);
        v = idle_vec();
        step(v, "clr_after");
        chk_fsm("clr_after", 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            v = idle_vec();
            v.re = 1'b1; v.a1 = 5'(i); v.a2 = 5'(31 - i);
            step(v, $sformatf("cleared_rd%0d", i));
        end

        // Reset during the tenth cycle of a clear aborts it
        for (int i = 1; i < 32; i++) begin
            v = idle_vec();
            v.we = 1'b1; v.wa = 5'(i); v.wd = 32'h100 + 32'(i);
            step(v, $sformatf("refill%0d", i));
        end
        v = idle_vec();
        v.cs = 1'b1;
        step(v, "abort_start");
        for (int k = 1; k < 10; k++) begin
            v = idle_vec();
            step(v, $sformatf("abort_run%0d", k));
            chk_fsm($sformatf("abort_run%0d", k), 1'b1, 1'b0);
        end
        async_reset("abort_rst");
        for (int k = 0; k < 40; k++) begin
            v = idle_vec();
            step(v, $sformatf("abort_quiet%0d", k));
            chk_fsm($sformatf("abort_quiet%0d", k), 1'b0, 1'b0);
        end

        // Fresh clear with clear_start held high through clear_done
        v = idle_vec();
        v.cs = 1'b1;
        step(v, "b2b_start");
        chk_fsm("b2b_start", 1'b1, 1'b0);
        for (int k = 0; k < 32; k++) begin
            step(v, $sformatf("b2b_first%0d", k));
            chk_fsm($sformatf("b2b_first%0d", k), k < 31, k == 31);
        end
        step(v, "b2b_restart");
        chk_fsm("b2b_restart", 1'b1, 1'b0);
        v.cs = 1'b0;
        for (int k = 0; k < 32; k++) begin
            step(v, $sformatf("b2b_second%0d", k));
            chk_fsm($sformatf("b2b_second%0d", k), k < 31, k == 31);
        end
        v = idle_vec();
        v.re = 1'b1; v.a1 = 5'd17; v.a2 = 5'd0;
        step(v, "b2b_rd");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
